// File: rtl/scan_ctrl_pkg.sv
// Purpose: shared types and constants for the scan-chain test controller.
// Contents: controller state enum and the largest supported chain length.
package scan_ctrl_pkg;

  localparam int unsigned SCAN_LEN_MAX = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CAPT,
    ST_UNLOAD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/scan_shift_reg.sv
// Purpose: WIDTH-bit right-shift register with parallel load and serial-in.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         parallel load of load_val (wins over shift)
//   load_val     parallel load value
//   shift        shift right by one, sin enters the MSB
//   sin          serial input
//   q            register contents
module scan_shift_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Purpose: scan-chain controller running load / capture / unload per request.
// Ports:
//   CLK, RSTB  clock (shared with chain flops), async active-low reset
//   START      request pulse, honoured only in IDLE
//   ABORT      synchronous abort back to IDLE (wins over START)
//   PATTERN    load pattern, latched when START is accepted
//   SO         scan-out of the last chain flop
//   SE, SI     registered scan enable / scan-in to the chain
//   RESULT     unloaded chain contents, updated when DONE rises
//   BUSY       high in LOAD, CAPT and UNLOAD
//   DONE       one-cycle completion pulse
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 32
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CHAIN_LEN-1:0] PATTERN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic [CHAIN_LEN-1:0] RESULT,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int unsigned    CNT_W    = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] pat_q;
  logic [CHAIN_LEN-1:0] res_q;
  logic                 accept;
  logic                 se_d;
  logic                 si_d;
  logic                 busy_d;
  logic                 done_d;
  logic                 result_we;
  logic                 unused_bits;

  assign accept = (state == ST_IDLE) && START && !ABORT;

  // Only pat_q[1] feeds SI and res_q[0] falls off the end of the unload shift.
  assign unused_bits = ^{pat_q, res_q[0]};

  // Pattern shifter: pat_q[0] tracks the bit currently on SI.
  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_pat_sr (
    .clk      (CLK),
    .rst_n    (RSTB),
    .load     (accept),
    .load_val (PATTERN),
    .shift    (state == ST_LOAD),
    .sin      (1'b0),
    .q        (pat_q)
  );

  // Result shifter: collects SO, first sample ends up in bit 0.
  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_res_sr (
    .clk      (CLK),
    .rst_n    (RSTB),
    .load     (accept),
    .load_val ('0),
    .shift    ((state == ST_UNLOAD) && !ABORT),
    .sin      (SO),
    .q        (res_q)
  );

  // State register.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; ABORT overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (START) state_nxt = ST_LOAD;
      ST_LOAD:   if (cnt == CNT_LAST) state_nxt = ST_CAPT;
      ST_CAPT:   state_nxt = ST_UNLOAD;
      ST_UNLOAD: if (cnt == CNT_LAST) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (ABORT) state_nxt = ST_IDLE;
  end

  // Output decode from the upcoming state so the pins are flop outputs.
  always_comb begin
    se_d      = 1'b0;
    si_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    result_we = 1'b0;
    case (state_nxt)
      ST_LOAD: begin
        se_d   = 1'b1;
        busy_d = 1'b1;
        // First load bit comes straight from PATTERN; later ones from the shifter.
        si_d   = (state == ST_IDLE) ? PATTERN[0] : pat_q[1];
      end
      ST_CAPT:   busy_d = 1'b1;
      ST_UNLOAD: begin
        se_d   = 1'b1;
        busy_d = 1'b1;
      end
      ST_DONE: begin
        done_d    = 1'b1;
        result_we = (state == ST_UNLOAD);
      end
      default: ;
    endcase
  end

  // Phase counter, cleared on every state change, so it never wraps mid-phase.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if ((state == ST_LOAD) || (state == ST_UNLOAD)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Output registers; RESULT takes the final unload sample on the same edge DONE rises.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      SE     <= 1'b0;
      SI     <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      RESULT <= '0;
    end else begin
      SE   <= se_d;
      SI   <= si_d;
      BUSY <= busy_d;
      DONE <= done_d;
      if (result_we) RESULT <= {SO, res_q[CHAIN_LEN-1:1]};
    end
  end

endmodule
